// File: rtl/var_bw_mul_pkg.sv
// -----------------------------------------------------------------------------
// var_bw_mul_pkg
// Shared types and helpers for the variable bit-width pipelined multiplier.
//   mode_e       : operation mode (full, two lanes, four lanes, reserved)
//   lane_count() : number of independent lanes a mode splits the operands into
//   stage_t      : contents of one pipeline stage (valid, mode, err, product)
// -----------------------------------------------------------------------------
package var_bw_mul_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Product field is sized for the widest supported operand (WIDTH = 64).
    // Narrower instances zero-extend into it and synthesis trims the rest.
    localparam int MAX_WIDTH = 64;
    localparam int STG_P_W   = 2 * MAX_WIDTH;

    // The reserved mode is evaluated as a full-width product.
    function automatic int unsigned lane_count(input mode_e m);
        int unsigned n;
        case (m)
            MODE_HALF:    n = 2;
            MODE_QUARTER: n = 4;
            default:      n = 1;
        endcase
        return n;
    endfunction

    typedef struct packed {
        logic                 valid;
        mode_e                mode;
        logic                 err;
        logic [STG_P_W-1:0]   product;
    } stage_t;

endpackage

// File: rtl/var_bw_mul_core.sv
// -----------------------------------------------------------------------------
// var_bw_mul_core
// Purely combinational partitioned multiplier. Each operand is cut into four
// quarters of Q = WIDTH/4 bits; all 16 quarter-by-quarter sub-products are
// formed and only those whose quarters fall in the same lane are summed.
//   mode : 0 full, 1 two lanes, 2 four lanes, 3 treated as full
//   a, b : WIDTH-bit unsigned operands
//   p    : 2*WIDTH-bit result, lane k at p[k*2L +: 2L]
// -----------------------------------------------------------------------------
module var_bw_mul_core
    import var_bw_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int Q   = WIDTH / 4;
    localparam int P_W = 2 * WIDTH;

    int unsigned    grp;
    logic [Q-1:0]   a_q;
    logic [Q-1:0]   b_q;
    logic [2*Q-1:0] pp;
    logic [P_W-1:0] acc;

    // Sub-product a_i*b_j carries weight 2^((i+j)*Q). Within a lane of G
    // quarters the same shift lands the lane product at its own 2L-bit slot,
    // so masking out cross-lane pairs is all that separates the lanes. Each
    // lane product fits in 2L bits, so no sum can spill into the next lane.
    always_comb begin
        grp = 4 / lane_count(mode_e'(mode));
        a_q = '0;
        b_q = '0;
        pp  = '0;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ((i / grp) == (j / grp)) begin
                    a_q = a[i*Q +: Q];
                    b_q = b[j*Q +: Q];
                    pp  = {{Q{1'b0}}, a_q} * {{Q{1'b0}}, b_q};
                    acc = acc + (P_W'(pp) << ((i + j) * Q));
                end
            end
        end
    end

    assign p = acc;

endmodule

// File: rtl/var_bw_mul_pipe.sv
// -----------------------------------------------------------------------------
// var_bw_mul_pipe
// Pipelined variable bit-width multiplier with valid/ready on both sides.
// The combinational core sits ahead of stage 0; LATENCY register stages then
// carry valid, mode, err and product. All stages advance together whenever
// the output slot is empty or being taken, otherwise everything holds.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   in_mode, in_a, in_b : mode and WIDTH-bit operands
//   out_valid/out_ready : result handshake
//   out_p               : 2*WIDTH-bit product(s)
//   out_mode, out_err   : mode of the result, set err for reserved mode 3
// -----------------------------------------------------------------------------
module var_bw_mul_pipe
    import var_bw_mul_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [1:0]         out_mode,
    output logic               out_err
);

    localparam int P_W = 2 * WIDTH;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("var_bw_mul_pipe: WIDTH must be a multiple of 4 in 8..64");
        end
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("var_bw_mul_pipe: LATENCY must be 1..4");
        end
    endgenerate

    stage_t         stage_q [LATENCY];
    logic [P_W-1:0] core_p;
    logic           adv;

    var_bw_mul_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode (in_mode),
        .a    (in_a),
        .b    (in_b),
        .p    (core_p)
    );

    // Whole pipe moves as one shift register; a stalled output freezes every
    // stage, so bubbles stay in place and order is preserved.
    assign adv      = !stage_q[LATENCY-1].valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                stage_q[s] <= '0;
            end
        end else if (adv) begin
            // stage 0: capture core result with its control
            stage_q[0].valid   <= in_valid;
            stage_q[0].mode    <= mode_e'(in_mode);
            stage_q[0].err     <= (mode_e'(in_mode) == MODE_RSVD);
            stage_q[0].product <= STG_P_W'(core_p);
            // stages 1..LATENCY-1: plain shift
            for (int s = 1; s < LATENCY; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign out_valid = stage_q[LATENCY-1].valid;
    assign out_mode  = stage_q[LATENCY-1].mode;
    assign out_err   = stage_q[LATENCY-1].err;
    assign out_p     = stage_q[LATENCY-1].product[P_W-1:0];

    // Upper product bits are always zero for narrow instances; fold them
    // into a sink so they are visibly intentional.
    generate
        if (P_W < STG_P_W) begin : g_hi_sink
            logic unused_hi;
            assign unused_hi = ^stage_q[LATENCY-1].product[STG_P_W-1:P_W];
        end
    endgenerate

endmodule

// File: tb/tb_var_bw_mul_pipe.sv
module tb_var_bw_mul_pipe;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic [1:0]    out_mode;
    logic          out_err;

    var_bw_mul_pipe #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_mode  (out_mode),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic [1:0]     m;
        logic           e;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: per-lane multiply of extracted operand slices.
    function automatic logic [2*W-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int n;
        int l;
        logic [2*W-1:0] r;
        logic [2*W-1:0] mask;
        logic [2*W-1:0] la;
        logic [2*W-1:0] lb;
        n = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
        l = W / n;
        mask = (l == W) ? {W{1'b1}} : ((2*W)'(1) << l) - 1;
        r = '0;
        for (int k = 0; k < n; k++) begin
            la = ((2*W)'(a) >> (k*l)) & mask;
            lb = ((2*W)'(b) >> (k*l)) & mask;
            r  = r | ((la * lb) << (k*2*l));
        end
        return r;
    endfunction

    // Drive a beat right after a posedge and hold it until accepted.
    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.p = model(m, a, b);
                e.m = m;
                e.e = (m == 2'd3);
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_val("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain", 64'(sb.size()), 64'(0));
    endtask

    // Output monitor/scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", 64'(out_p), 64'(0));
                    check_val("spurious_vld", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check_val("out_p",    64'(out_p),    64'(e.p));
                    check_val("out_mode", 64'(out_mode), 64'(e.m));
                    check_val("out_err",  64'(out_err),  64'(e.e));
                end
            end else begin
                check_val("stall_in_ready", 64'(in_ready), 64'(0));
                if (sb.size() != 0) begin
                    check_val("stall_hold_p", 64'(out_p), 64'(sb[0].p));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_p",     64'(out_p),     64'(0));
        check_val("rst_out_mode",  64'(out_mode),  64'(0));
        check_val("rst_out_err",   64'(out_err),   64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_in_ready",  64'(in_ready),  64'(1));

        // Full mode with latency check
        send(2'd0, 16'hFFFF, 16'hFFFF);
        check_val("lat_early", 64'(out_valid), 64'(0));
        repeat (LAT-1) begin
            @(posedge clk);
            #1;
        end
        check_val("lat_on", 64'(out_valid), 64'(1));
        check_val("full_p", 64'(out_p), 64'(32'hFFFE0001));
        wait_drain();

        // Half, quarter, reserved
        send(2'd1, 16'h12FF, 16'h34FF);
        wait_drain();
        send(2'd2, 16'hFFFF, 16'hFFFF);
        wait_drain();
        send(2'd3, 16'hFFFF, 16'hFFFF);
        wait_drain();
        check_val("model_half", 64'(model(2'd1, 16'h12FF, 16'h34FF)), 64'(32'h03A8FE01));

        // Backpressure: 5 beats, 4-cycle stall mid-stream
        fork
            begin
                for (int i = 1; i <= 5; i++) send(2'd0, 16'(i), 16'd3);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Back-to-back mode switch plus random lanes
        send(2'd0, 16'hFFFF, 16'hFFFF);
        send(2'd1, 16'hFFFF, 16'hFFFF);
        send(2'd2, 16'hFFFF, 16'hFFFF);
        send(2'd0, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 12; i++) begin
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end
        wait_drain();

        // Reset with two beats in flight
        send(2'd0, 16'd7, 16'd9);
        send(2'd2, 16'h1234, 16'h5678);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'(0));
        check_val("arst_out_p",     64'(out_p),     64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("post_rst_idle", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send(2'd1, 16'hA5C3, 16'h3C5A);
        check_val("post_rst_lat_early", 64'(out_valid), 64'(0));
        repeat (LAT-1) begin
            @(posedge clk);
            #1;
        end
        check_val("post_rst_lat_on", 64'(out_valid), 64'(1));
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
